instruction_fetch: RTL
======================

# instruction_fetch

Pipeline stage 1 of the MIPS-style processor: holds the program counter, reads the instruction memory and drives the IF/ID pipeline register consumed by the decode stage. It honours the decode-stage hazard stall (PC write / IF-ID write enables), redirects and flushes on a taken branch, and stops fetching on a HALT word. A debug program-load port writes instruction memory while the stage is disabled.

## Interface
- PC_BITS, 32, program counter width (word address)
- INSTRUCTION_BITS, 32, instruction width
- IMEM_ADDR_BITS, 10, instruction memory index width (2^10 words)

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- i_enable  in  1  run enable; 0 freezes all stage state
- i_PCWrite  in  1  from hazard detector; 0 holds PC
- i_if_id_write  in  1  from hazard detector; 0 holds IF/ID register
- i_branch_taken  in  1  branch resolved taken this cycle
- i_branch_target  in  PC_BITS  redirect address (word)
- i_prog_we  in  1  instruction memory write strobe (honoured only when i_enable=0)
- i_prog_addr  in  IMEM_ADDR_BITS  program-load address
- i_prog_data  in  INSTRUCTION_BITS  program-load word
- o_instruction  out  INSTRUCTION_BITS  IF/ID instruction
- o_PCNext  out  PC_BITS  IF/ID PC+1 of that instruction
- o_pc  out  PC_BITS  current PC (debug)
- o_halted  out  1  HALT has entered IF/ID; fetch stopped

## Operation
- Word addressing: PC+1 per instruction; memory index = PC[IMEM_ADDR_BITS-1:0]; PC+1 wraps modulo 2^PC_BITS, index wraps modulo memory size.
- Memory: synchronous write, asynchronous read; fetched word = imem[PC index].
- Per-cycle priority (highest first):
  1. rst=0: PC=0, o_instruction=0 (NOP), o_PCNext=0, o_halted=0. Memory contents not reset.
  2. i_enable=0: PC, IF/ID, halted all hold; i_prog_we=1 writes i_prog_data to imem[i_prog_addr].
  3. i_branch_taken=1: PC <= i_branch_target; IF/ID <= NOP, o_PCNext <= 0; o_halted <= 0. Overrides i_PCWrite=0, i_if_id_write=0 and halted state (squashed wrong-path HALT).
  4. o_halted=1: PC holds; IF/ID loads NOP if i_if_id_write=1, else holds.
  5. Normal: if i_PCWrite, PC <= PC+1; if i_if_id_write, IF/ID <= {fetched word, PC+1}. If fetched word == HALT_INSTR (all ones) and i_if_id_write=1, PC holds instead of incrementing and o_halted <= 1 the same edge.
- i_prog_we while i_enable=1 is ignored.
- Stall with i_PCWrite=1, i_if_id_write=0 is legal (PC advances, IF/ID holds); hazard unit drives both low together in practice.

## Timing
- Fetch latency: instruction at PC appears on o_instruction one edge after PC presents it.
- Branch penalty: instruction in IF at redirect edge is replaced by NOP; target instruction on o_instruction 2 edges after i_branch_taken sampled.
- o_halted asserts on the edge HALT is registered into IF/ID; o_pc frozen at HALT address from that edge.
- Program write visible to fetch the cycle after the write edge.
- Reset mid-run: next edge returns all outputs to reset values, regardless of stall/branch/halt.

## Structure
- constants.vh gains IMEM_ADDR_BITS, HALT_INSTR (32'hFFFF_FFFF), NOP_INSTR (32'h0000_0000); PC_BITS and INSTRUCTION_BITS reused.
- Sub-module instruction_memory: sync write port, async read port, parameterised by IMEM_ADDR_BITS and INSTRUCTION_BITS.
- PC register, halt flag and IF/ID register live in instruction_fetch.

## Test plan
- Load imem[0..3]=0x20010005,0x20020007,0x00221820,HALT with i_enable=0, then enable -> o_instruction sequence 0x20010005,0x20020007,0x00221820,HALT; o_PCNext 1,2,3,4; o_halted=1 with o_pc=3, then NOP thereafter.
- Stall: i_PCWrite=i_if_id_write=0 for 2 cycles at PC=2 -> o_pc stays 2, o_instruction stays imem[1] value, resumes with imem[2].
- Branch: i_branch_taken=1, target=0x10 while stalled -> next edge o_pc=0x10, o_instruction=0; following edge o_instruction=imem[0x10], o_PCNext=0x11.
- Squashed halt: HALT in IF/ID (o_halted=1), then i_branch_taken target=0 -> o_halted=0, fetch restarts at 0.
- Wrap: PC=0x3FF fetch -> next index 0 (PC=0x400); PC=0xFFFFFFFF -> PC+1=0.
- Reset/disable: rst=0 mid-branch -> all outputs 0; i_enable=0 with i_prog_we pulse -> PC and IF/ID unchanged, memory word updated; i_prog_we with i_enable=1 -> memory unchanged.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch stage.
//   DEF_* : default widths used by instruction_fetch and instruction_memory
//   HALT_INSTR / NOP_INSTR : special instruction encodings
package instruction_fetch_pkg;

    localparam int DEF_PC_BITS          = 32;
    localparam int DEF_INSTRUCTION_BITS = 32;
    localparam int DEF_IMEM_ADDR_BITS   = 10;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_memory.sv
// Instruction memory: one synchronous write port (program load) and one
// asynchronous read port (fetch). Contents are never reset.
//   clk      : clock
//   we_i     : write strobe
//   waddr_i  : write index
//   wdata_i  : write word
//   raddr_i  : fetch index
//   rdata_o  : fetched word (combinational)
module instruction_memory
    import instruction_fetch_pkg::*;
#(
    parameter int IMEM_ADDR_BITS   = DEF_IMEM_ADDR_BITS,
    parameter int INSTRUCTION_BITS = DEF_INSTRUCTION_BITS
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [IMEM_ADDR_BITS-1:0]   waddr_i,
    input  logic [INSTRUCTION_BITS-1:0] wdata_i,
    input  logic [IMEM_ADDR_BITS-1:0]   raddr_i,
    output logic [INSTRUCTION_BITS-1:0] rdata_o
);

    logic [INSTRUCTION_BITS-1:0] mem_q [0:(1<<IMEM_ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program counter, instruction memory read and IF/ID register.
// Honours hazard stalls, branch redirect/flush, and stops on a HALT word.
// Instruction memory is loadable through the prog port while disabled.
//   clk, rst (sync, active-low)
//   i_enable         : run enable, 0 freezes all stage state
//   i_PCWrite        : 0 holds PC
//   i_if_id_write    : 0 holds IF/ID
//   i_branch_taken   : redirect to i_branch_target, flush IF/ID
//   i_prog_*         : program-load write port
//   o_instruction    : IF/ID instruction
//   o_PCNext         : IF/ID PC+1
//   o_pc             : current PC
//   o_halted         : HALT registered into IF/ID
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int PC_BITS          = DEF_PC_BITS,
    parameter int INSTRUCTION_BITS = DEF_INSTRUCTION_BITS,
    parameter int IMEM_ADDR_BITS   = DEF_IMEM_ADDR_BITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_enable,
    input  logic                        i_PCWrite,
    input  logic                        i_if_id_write,
    input  logic                        i_branch_taken,
    input  logic [PC_BITS-1:0]          i_branch_target,
    input  logic                        i_prog_we,
    input  logic [IMEM_ADDR_BITS-1:0]   i_prog_addr,
    input  logic [INSTRUCTION_BITS-1:0] i_prog_data,
    output logic [INSTRUCTION_BITS-1:0] o_instruction,
    output logic [PC_BITS-1:0]          o_PCNext,
    output logic [PC_BITS-1:0]          o_pc,
    output logic                        o_halted
);

    localparam logic [INSTRUCTION_BITS-1:0] HALT_W = INSTRUCTION_BITS'(HALT_INSTR);
    localparam logic [INSTRUCTION_BITS-1:0] NOP_W  = INSTRUCTION_BITS'(NOP_INSTR);

    logic [PC_BITS-1:0]          pc_q, pc_d;
    logic [INSTRUCTION_BITS-1:0] instr_q, instr_d;
    logic [PC_BITS-1:0]          pcnext_q, pcnext_d;
    logic                        halted_q, halted_d;

    logic [INSTRUCTION_BITS-1:0] fetched;
    logic [PC_BITS-1:0]          pc_plus1;
    logic                        halt_fetch;
    logic                        mem_we;

    // Writes are blocked during reset and whenever the stage is running.
    assign mem_we = rst & ~i_enable & i_prog_we;

    instruction_memory #(
        .IMEM_ADDR_BITS  (IMEM_ADDR_BITS),
        .INSTRUCTION_BITS(INSTRUCTION_BITS)
    ) u_imem (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(i_prog_addr),
        .wdata_i(i_prog_data),
        .raddr_i(pc_q[IMEM_ADDR_BITS-1:0]),
        .rdata_o(fetched)
    );

    assign pc_plus1   = pc_q + PC_BITS'(1);
    // HALT only stops the PC once it actually enters IF/ID.
    assign halt_fetch = (fetched == HALT_W) && i_if_id_write;

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcnext_d = pcnext_q;
        halted_d = halted_q;
        if (!i_enable) begin
            // frozen
        end else if (i_branch_taken) begin
            // Branch also squashes a wrong-path HALT.
            pc_d     = i_branch_target;
            instr_d  = NOP_W;
            pcnext_d = '0;
            halted_d = 1'b0;
        end else if (halted_q) begin
            if (i_if_id_write) begin
                instr_d  = NOP_W;
                pcnext_d = '0;
            end
        end else begin
            if (i_PCWrite && !halt_fetch) begin
                pc_d = pc_plus1;
            end
            if (i_if_id_write) begin
                instr_d  = fetched;
                pcnext_d = pc_plus1;
            end
            if (halt_fetch) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= '0;
            instr_q  <= NOP_W;
            pcnext_q <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcnext_q <= pcnext_d;
            halted_q <= halted_d;
        end
    end

    assign o_instruction = instr_q;
    assign o_PCNext      = pcnext_q;
    assign o_pc          = pc_q;
    assign o_halted      = halted_q;

endmodule
